// File: rtl/ball_frame_renderer_pkg.sv
// Shared VGA timing defaults, colour type and the ball position clamp.
package ball_frame_renderer_pkg;

   localparam int CLK_DIV_D   = 4;
   localparam int H_VISIBLE_D = 640;
   localparam int H_FP_D      = 16;
   localparam int H_SYNC_D    = 96;
   localparam int H_BP_D      = 48;
   localparam int V_VISIBLE_D = 480;
   localparam int V_FP_D      = 10;
   localparam int V_SYNC_D    = 2;
   localparam int V_BP_D      = 33;
   localparam int BALL_SIZE_D = 8;

   localparam int H_TOTAL_D = H_VISIBLE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int V_TOTAL_D = V_VISIBLE_D + V_FP_D + V_SYNC_D + V_BP_D;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t RGB_BALL = 12'hFFF;
   localparam rgb_t RGB_OFF  = 12'h000;

   // Negative positions pin to 0, anything past max_pos pins to max_pos.
   function automatic logic [9:0] clamp_pos(input logic [31:0] pos, input logic [9:0] max_pos);
      logic [9:0] res;
      if (pos[31])
         res = '0;
      else if (pos > {22'd0, max_pos})
         res = max_pos;
      else
         res = pos[9:0];
      return res;
   endfunction

endpackage

// File: rtl/ball_frame_renderer_vga_timing_gen.sv
// Pixel-tick divider and raster h/v counters.
module vga_timing_gen
   import ball_frame_renderer_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_D,
   parameter int H_TOTAL   = H_TOTAL_D,
   parameter int V_TOTAL   = V_TOTAL_D,
   parameter int V_VISIBLE = V_VISIBLE_D
)(
   input  logic       clock,
   input  logic       reset,
   output logic       tick,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       frame_wrap
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);

   logic [DIV_W-1:0] div;

   assign tick = (div == DIV_LAST);
   // Level: counters sit on the last pixel of the visible frame; the caller qualifies with tick.
   assign frame_wrap = (h == H_LAST) && (v == V_VIS_LAST);

   // Divider counts 0..CLK_DIV-1 and raises tick on its last count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         div <= '0;
      else if (tick)
         div <= '0;
      else
         div <= div + DIV_W'(1);
   end

   // h advances every tick; v advances when h wraps.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (tick) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
         end else begin
            h <= h + 10'd1;
         end
      end
   end

endmodule

// File: rtl/ball_frame_renderer.sv
// VGA display stage: latches the ball once per frame and draws it as a white square.
module ball_frame_renderer
   import ball_frame_renderer_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_D,
   parameter int H_VISIBLE = H_VISIBLE_D,
   parameter int H_FP      = H_FP_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BP      = H_BP_D,
   parameter int V_VISIBLE = V_VISIBLE_D,
   parameter int V_FP      = V_FP_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BP      = V_BP_D,
   parameter int BALL_SIZE = BALL_SIZE_D
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ball_x,
   input  logic [31:0] ball_y,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        screen_end,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
   localparam logic [9:0]  BX_MAX   = 10'(H_VISIBLE - BALL_SIZE);
   localparam logic [9:0]  BY_MAX   = 10'(V_VISIBLE - BALL_SIZE);

   logic        tick;
   logic        frame_wrap;
   logic [9:0]  h, v;
   logic [9:0]  bx, by;
   logic [10:0] h_w, v_w, bx_w, by_w;
   logic        vis, ball_pixel, blank_entry;
   rgb_t        rgb;

   vga_timing_gen #(
      .CLK_DIV   (CLK_DIV),
      .H_TOTAL   (H_TOTAL),
      .V_TOTAL   (V_TOTAL),
      .V_VISIBLE (V_VISIBLE)
   ) u_timing (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .h          (h),
      .v          (v),
      .frame_wrap (frame_wrap)
   );

   // 11-bit compares so bx+BALL_SIZE cannot wrap.
   assign h_w  = {1'b0, h};
   assign v_w  = {1'b0, v};
   assign bx_w = {1'b0, bx};
   assign by_w = {1'b0, by};

   assign vis         = (h_w < H_VIS) && (v_w < V_VIS);
   assign ball_pixel  = vis && (h_w >= bx_w) && (h_w < bx_w + BALL_W)
                            && (v_w >= by_w) && (v_w < by_w + BALL_W);
   // Single clock (not a whole pixel tick) at the v 479->480 step.
   assign blank_entry = tick && frame_wrap;

   // Ball position is sampled only at blanking entry so a frame never tears.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bx <= '0;
         by <= '0;
      end else if (blank_entry) begin
         bx <= clamp_pos(ball_x, BX_MAX);
         by <= clamp_pos(ball_y, BY_MAX);
      end
   end

   // All outputs registered from the same counter state so they stay mutually aligned.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         video_on   <= 1'b0;
         pixel_x    <= '0;
         pixel_y    <= '0;
         screen_end <= 1'b0;
         rgb        <= RGB_OFF;
      end else begin
         hsync      <= !((h_w >= HS_START) && (h_w < HS_END));
         vsync      <= !((v_w >= VS_START) && (v_w < VS_END));
         video_on   <= vis;
         pixel_x    <= h;
         pixel_y    <= v;
         screen_end <= blank_entry;
         rgb        <= ball_pixel ? RGB_BALL : RGB_OFF;
      end
   end

   assign vga_r = rgb.r;
   assign vga_g = rgb.g;
   assign vga_b = rgb.b;

endmodule

// File: tb/tb_ball_frame_renderer.sv
// Scoreboard bench: a full-size instance checks divider and line timing, a shrunken
// instance (CLK_DIV=2, 120x68 raster, 112x64 visible) checks frames, latching and clamping.
module tb_ball_frame_renderer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ball_x, ball_y;

   always #5 clk = ~clk;

   logic       f_hs, f_vs, f_von, f_se;
   logic [9:0] f_px, f_py;
   logic [3:0] f_r, f_g, f_b;
   logic       s_hs, s_vs, s_von, s_se;
   logic [9:0] s_px, s_py;
   logic [3:0] s_r, s_g, s_b;

   ball_frame_renderer u_full (
      .clock(clk), .reset(rst), .ball_x(ball_x), .ball_y(ball_y),
      .hsync(f_hs), .vsync(f_vs), .video_on(f_von), .pixel_x(f_px), .pixel_y(f_py),
      .screen_end(f_se), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b)
   );

   ball_frame_renderer #(
      .CLK_DIV(2), .H_VISIBLE(112), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_VISIBLE(64), .V_FP(2), .V_SYNC(1), .V_BP(1), .BALL_SIZE(8)
   ) u_small (
      .clock(clk), .reset(rst), .ball_x(ball_x), .ball_y(ball_y),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .pixel_x(s_px), .pixel_y(s_py),
      .screen_end(s_se), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
   );

   typedef struct { int x; int y; logic [11:0] rgb; } pix_t;
   typedef struct { int off; int width; int period; } hs_t;

   pix_t pix_q[$];
   hs_t  hs_q[$];
   int   se_q[$];
   int   lat_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dec_bad = 0;

   // {hsync, vsync, video_on, screen_end, pixel_x, pixel_y, rgb}
   localparam logic [35:0] RST_SNAP = {4'b1100, 10'd0, 10'd0, 12'h000};

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] f_snap();
      return {f_hs, f_vs, f_von, f_se, f_px, f_py, f_r, f_g, f_b};
   endfunction

   function automatic logic [35:0] s_snap();
      return {s_hs, s_vs, s_von, s_se, s_px, s_py, s_r, s_g, s_b};
   endfunction

   task automatic exp_pix(input int x, input int y, input bit on);
      pix_t e;
      e.x = x; e.y = y; e.rgb = on ? 12'hFFF : 12'h000;
      pix_q.push_back(e);
   endtask

   task automatic wait_se(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!s_se && n < 20000);
      chk(name, s_se, 1);
   endtask

   task automatic wait_row(input int row);
      int n = 0;
      do begin @(negedge clk); n++; end while (s_py != row && n < 20000);
      chk("reach_row", s_py, row);
   endtask

   // Posedges since reset release.
   initial forever begin
      @(posedge clk);
      cyc = rst ? 0 : cyc + 1;
   end

   // Full-size monitor: first-tick latency, hsync placement/width and line period.
   initial begin
      int line_start, hs_fall, hs_prev_fall, hs_off;
      logic prev_hs;
      logic [9:0] prev_px;
      hs_t e;
      line_start = -1; hs_fall = 0; hs_prev_fall = 0; hs_off = 0;
      prev_hs = 1'b1; prev_px = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            line_start = -1; prev_hs = 1'b1; prev_px = '0;
         end else begin
            if (prev_px == 10'd0 && f_px == 10'd1 && lat_q.size() > 0)
               chk("px1_latency", cyc, lat_q.pop_front());
            if (prev_px != 10'd0 && f_px == 10'd0)
               line_start = cyc;
            if (prev_hs && !f_hs) begin
               hs_prev_fall = hs_fall;
               hs_fall      = cyc;
               hs_off       = cyc - line_start;
            end
            if (!prev_hs && f_hs && line_start >= 0 && hs_q.size() > 0) begin
               e = hs_q.pop_front();
               chk("hs_offset", hs_off, e.off);
               chk("hs_width", cyc - hs_fall, e.width);
               chk("line_period", hs_fall - hs_prev_fall, e.period);
            end
            prev_hs = f_hs;
            prev_px = f_px;
         end
      end
   end

   // Small-raster monitor: pixel colours, screen_end pulses, and sync/blank decode.
   initial begin
      logic prev_se;
      pix_t e;
      prev_se = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || cyc == 0) begin
            prev_se = 1'b0;
         end else begin
            if (s_von !== (s_px < 10'd112 && s_py < 10'd64)) dec_bad++;
            if (s_hs !== !(s_px >= 10'd114 && s_px < 10'd118)) dec_bad++;
            if (s_vs !== !(s_py == 10'd66)) dec_bad++;
            if (!s_von && {s_r, s_g, s_b} !== 12'h000) dec_bad++;
            if (pix_q.size() > 0 && s_von && s_px == pix_q[0].x && s_py == pix_q[0].y) begin
               e = pix_q.pop_front();
               chk($sformatf("rgb(%0d,%0d)", e.x, e.y), {s_r, s_g, s_b}, e.rgb);
            end
            if (prev_se)
               chk("se_after", {s_se, s_px, s_py}, {1'b0, 10'd0, 10'd64});
            if (s_se) begin
               chk("se_pending", se_q.size() > 0, 1);
               if (se_q.size() > 0) chk("se_cycle", cyc, se_q.pop_front());
               chk("se_pos", {s_px, s_py}, {10'd119, 10'd63});
            end
            prev_se = s_se;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      hs_t h;
      ball_x = 32'd100;
      ball_y = 32'd50;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_full", f_snap(), RST_SNAP);
      chk("reset_small", s_snap(), RST_SNAP);
      rst = 1'b0;
      lat_q.push_back(5);

      // Run into the first line, then reset asynchronously mid-line.
      n = 0;
      do begin @(negedge clk); n++; end while (f_px != 10'd300 && n < 2000);
      chk("reach_h300", f_px, 300);
      #2 rst = 1'b1;
      #1 chk("reset_midline_full", f_snap(), RST_SNAP);
      chk("reset_midline_small", s_snap(), RST_SNAP);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      lat_q.push_back(5);
      h.off = 2624; h.width = 384; h.period = 3200;
      hs_q.push_back(h);
      hs_q.push_back(h);
      se_q.push_back(15360);
      se_q.push_back(31680);
      se_q.push_back(48000);
      se_q.push_back(64320);

      // Frame 1: latched position still the reset value (0,0).
      exp_pix(0, 0, 1); exp_pix(7, 0, 1); exp_pix(8, 0, 0);
      exp_pix(0, 7, 1); exp_pix(0, 8, 0);

      // Frame 2: (100,50), and a mid-frame move must not show up.
      wait_se("se1");
      exp_pix(99, 50, 0); exp_pix(100, 50, 1); exp_pix(107, 50, 1); exp_pix(108, 50, 0);
      exp_pix(100, 57, 1); exp_pix(107, 57, 1); exp_pix(100, 58, 0);
      wait_row(30);
      ball_x = 32'd300;

      // Frame 3: x=300 clamps to 112-8=104.
      wait_se("se2");
      exp_pix(103, 50, 0); exp_pix(104, 50, 1); exp_pix(111, 50, 1);
      exp_pix(104, 57, 1); exp_pix(104, 58, 0);
      ball_x = 32'hFFFF_FFF0;
      ball_y = 32'd600;

      // Frame 4: negative x clamps to 0, y=600 clamps to 64-8=56.
      wait_se("se3");
      exp_pix(0, 55, 0); exp_pix(0, 56, 1); exp_pix(7, 56, 1); exp_pix(8, 56, 0);
      exp_pix(0, 63, 1); exp_pix(7, 63, 1);

      wait_se("se4");
      repeat (4) @(negedge clk);
      chk("pix_q_left", pix_q.size(), 0);
      chk("hs_q_left", hs_q.size(), 0);
      chk("se_q_left", se_q.size(), 0);
      chk("lat_q_left", lat_q.size(), 0);
      chk("decode_errors", dec_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
